// File: rtl/vga_pattern_gen_if.sv
// rtl/vga_pattern_gen_if.sv - timing/pattern inputs and RGB/sync outputs of the pattern generator
//
// Purpose: bundles the aligned sync/counter stream coming from the
// sync-to-count stage together with the registered RGB/sync outputs.
//   master : upstream/observer side, drives i_* and reads o_*
//   slave  : pattern generator side, reads i_* and drives o_*
// Signals:
//   i_HSync, i_VSync         syncs aligned with the counters
//   i_Col_Count, i_Row_Count current pixel position (10 bits)
//   i_Pattern                pattern select, used at frame start only
//   o_HSync, o_VSync         syncs delayed to line up with RGB
//   o_Red, o_Grn, o_Blu      3-bit colour levels
interface vga_pattern_gen_if;
  logic       i_HSync;
  logic       i_VSync;
  logic [9:0] i_Col_Count;
  logic [9:0] i_Row_Count;
  logic [2:0] i_Pattern;
  logic       o_HSync;
  logic       o_VSync;
  logic [2:0] o_Red;
  logic [2:0] o_Grn;
  logic [2:0] o_Blu;

  modport master (
    output i_HSync, i_VSync, i_Col_Count, i_Row_Count, i_Pattern,
    input  o_HSync, o_VSync, o_Red, o_Grn, o_Blu
  );

  modport slave (
    input  i_HSync, i_VSync, i_Col_Count, i_Row_Count, i_Pattern,
    output o_HSync, o_VSync, o_Red, o_Grn, o_Blu
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test pattern generator with registered RGB and delayed syncs
//
// Purpose: turns column/row counters into 3-bit-per-channel RGB test
// patterns, forced black outside the visible area, with syncs delayed one
// clock so they stay aligned with the registered colour.
// Ports:
//   i_Clk  pixel clock
//   i_Rst  synchronous reset, active-high
//   vga    slave side of vga_pattern_gen_if (counters/syncs/pattern in,
//          RGB/syncs out)
// Patterns: 0 black, 1 white, 2 checker, 3 colour bars, 4 moving bar,
//           5 red border, 6/7 black.
module vga_pattern_gen #(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CHECK_SHIFT = 5,
  parameter int BAR_WIDTH   = 16,
  parameter int BAR_STEP    = 4,
  parameter int BORDER_W    = 4
) (
  input logic              i_Clk,
  input logic              i_Rst,
  vga_pattern_gen_if.slave vga
);

  localparam int          BAR_COLS   = ACTIVE_COLS / 8;
  localparam logic [10:0] COLS_W     = 11'(ACTIVE_COLS);
  localparam logic [10:0] ROWS_W     = 11'(ACTIVE_ROWS);
  localparam logic [10:0] BORDER_WW  = 11'(BORDER_W);
  localparam logic [10:0] BAR_WIDTHW = 11'(BAR_WIDTH);
  localparam logic [10:0] BAR_STEPW  = 11'(BAR_STEP);
  localparam logic [9:0]  BAR_LAST   = 10'(BAR_COLS - 1);

  logic [10:0] col_w;
  logic [10:0] row_w;
  logic        active;
  logic        frame_start;

  logic [2:0]  pattern_q, pattern_d;
  logic [9:0]  bar_pos_q, bar_pos_d;
  logic [10:0] bar_sum;
  logic [10:0] bar_lo;
  logic [10:0] bar_hi;
  logic        in_bar;
  logic        in_border;

  logic [9:0]  bar_cnt_q, bar_cnt_d, bar_cnt_cur;
  logic [2:0]  bar_idx_q, bar_idx_d, bar_idx_cur;

  logic [8:0]  rgb_d, rgb_q;
  logic        hsync_q, vsync_q;

  assign col_w = {1'b0, vga.i_Col_Count};
  assign row_w = {1'b0, vga.i_Row_Count};

  always_comb begin
    frame_start = (vga.i_Col_Count == 10'd0) && (vga.i_Row_Count == 10'd0);
    active      = (col_w < COLS_W) && (row_w < ROWS_W);

    // Pattern and bar position update at (0,0) and already apply to that
    // pixel, so the "current" values are simply the next-state values.
    pattern_d = pattern_q;
    bar_pos_d = bar_pos_q;
    bar_sum   = {1'b0, bar_pos_q} + BAR_STEPW;
    if (frame_start) begin
      pattern_d = vga.i_Pattern;
      bar_pos_d = (bar_sum >= COLS_W) ? 10'(bar_sum - COLS_W) : 10'(bar_sum);
    end

    // 11-bit window so bar_pos + BAR_WIDTH never wraps; pixels past the
    // visible edge are removed by the blanking below.
    bar_lo = {1'b0, bar_pos_d};
    bar_hi = bar_lo + BAR_WIDTHW;
    in_bar = (col_w >= bar_lo) && (col_w < bar_hi);

    in_border = (col_w < BORDER_WW) || (col_w >= COLS_W - BORDER_WW) ||
                (row_w < BORDER_WW) || (row_w >= ROWS_W - BORDER_WW);

    // Colour-bar index tracked by counting pixels along the line instead of
    // dividing the column; col 0 restarts both counters for this pixel.
    bar_cnt_cur = (vga.i_Col_Count == 10'd0) ? 10'd0 : bar_cnt_q;
    bar_idx_cur = (vga.i_Col_Count == 10'd0) ? 3'd0  : bar_idx_q;
    bar_cnt_d   = bar_cnt_cur + 10'd1;
    bar_idx_d   = bar_idx_cur;
    if (bar_cnt_cur == BAR_LAST) begin
      bar_cnt_d = 10'd0;
      if (bar_idx_cur != 3'd7) begin
        bar_idx_d = bar_idx_cur + 3'd1;
      end
    end

    rgb_d = 9'o000;
    if (active) begin
      case (pattern_d)
        3'd1: rgb_d = 9'o777;
        3'd2: rgb_d = (vga.i_Col_Count[CHECK_SHIFT] ^ vga.i_Row_Count[CHECK_SHIFT])
                      ? 9'o777 : 9'o000;
        3'd3: begin
          case (bar_idx_cur)
            3'd0:    rgb_d = 9'o777;
            3'd1:    rgb_d = 9'o770;
            3'd2:    rgb_d = 9'o077;
            3'd3:    rgb_d = 9'o070;
            3'd4:    rgb_d = 9'o707;
            3'd5:    rgb_d = 9'o700;
            3'd6:    rgb_d = 9'o007;
            default: rgb_d = 9'o000;
          endcase
        end
        3'd4:    rgb_d = in_bar ? 9'o777 : 9'o007;
        3'd5:    rgb_d = in_border ? 9'o700 : 9'o000;
        default: rgb_d = 9'o000;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pattern_q <= 3'd0;
      bar_pos_q <= 10'd0;
      bar_cnt_q <= 10'd0;
      bar_idx_q <= 3'd0;
      rgb_q     <= 9'o000;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      bar_pos_q <= bar_pos_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      rgb_q     <= rgb_d;
      hsync_q   <= vga.i_HSync;
      vsync_q   <= vga.i_VSync;
    end
  end

  assign vga.o_Red   = rgb_q[8:6];
  assign vga.o_Grn   = rgb_q[5:3];
  assign vga.o_Blu   = rgb_q[2:0];
  assign vga.o_HSync = hsync_q;
  assign vga.o_VSync = vsync_q;

endmodule
